// File: rtl/ex_alu_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_alu_stage
// Brief    : MIPS execute-stage ALU with registered EX/MEM result. Optional
//            iterative shift-add multiply enabled by macro ALU_MUL_EN.
// Revision : 1.0  initial release
// ============================================================================
module ex_alu_stage #(
    parameter int WIDTH     = 32,
    parameter int MUL_STEPS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam logic [3:0] c_add = 4'b0000;
    localparam logic [3:0] c_sub = 4'b0001;
    localparam logic [3:0] c_slt = 4'b1000;
    localparam logic [3:0] c_and = 4'b0010;
    localparam logic [3:0] c_or  = 4'b0011;

    if (MUL_STEPS != WIDTH) begin : g_param_check
        $error("ex_alu_stage: MUL_STEPS must equal WIDTH");
    end

    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_illegal;
    logic             r_out_valid;
    logic [WIDTH-1:0] w_res;
    logic             w_illegal;

    // Single-cycle datapath; unknown or unsupported codes fall to default.
    always_comb begin
        w_res     = '0;
        w_illegal = 1'b0;
        case (alu_ctrl)
            c_add:   w_res = op_a + op_b;
            c_sub:   w_res = op_a - op_b;
            c_slt:   w_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            c_and:   w_res = op_a & op_b;
            c_or:    w_res = op_a | op_b;
            default: begin
                w_res     = '0;
                w_illegal = 1'b1;
            end
        endcase
    end

`ifdef ALU_MUL_EN
    localparam logic [3:0] c_mul  = 4'b0110;
    localparam int         c_cw   = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(MUL_STEPS - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t            r_state;
    logic [c_cw-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign busy       = (r_state == S_MUL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            // Abort without touching the last architectural result.
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_out_valid <= 1'b0;
                    if (in_valid) begin
                        if (alu_ctrl == c_mul) begin
                            r_mcand  <= op_a;
                            r_mplier <= op_b;
                            r_acc    <= '0;
                            r_cnt    <= '0;
                            r_state  <= S_MUL;
                        end else begin
                            r_result    <= w_res;
                            r_zero      <= (w_res == '0);
                            r_illegal   <= w_illegal;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + c_cw'(1);
                    if (r_cnt == c_last) begin
                        r_result    <= w_acc_next;
                        r_zero      <= (w_acc_next == '0);
                        r_illegal   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
            endcase
        end
    end
`else
    assign busy = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_result  <= w_res;
                r_zero    <= (w_res == '0);
                r_illegal <= w_illegal;
            end
        end
    end
`endif

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_ex_alu_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_alu_stage
// Brief    : Directed self-checking bench for ex_alu_stage (both ALU_MUL_EN builds).
// Revision : 1.0  initial release
// ============================================================================
module tb_ex_alu_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int n_tests = 0;
    int n_fail  = 0;

    ex_alu_stage #(.WIDTH(32), .MUL_STEPS(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .busy      (busy),
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic f);
        in_valid = v;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        flush    = f;
    endtask

    // Advance one rising edge and sample just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] res, input logic ov,
                           input logic z, input logic ill, input logic bsy);
        chk({tag, ".result"},    result,           res);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
        chk({tag, ".zero"},      {31'd0, zero},      {31'd0, z});
        chk({tag, ".illegal"},   {31'd0, illegal},   {31'd0, ill});
        chk({tag, ".busy"},      {31'd0, busy},      {31'd0, bsy});
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);
        tick();
        tick();
        chk_out("reset", 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;

        drive(1'b1, 4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        tick();
        chk_out("add_ovf", 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);
        tick();
        chk_out("add_hold", 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0);

        drive(1'b1, 4'b0001, 32'd5, 32'd5, 1'b0);
        tick();
        chk_out("sub_zero", 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 4'b1000, 32'hFFFF_FFFF, 32'd1, 1'b0);
        tick();
        chk_out("slt_neg", 32'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'b1000, 32'd1, 32'hFFFF_FFFF, 1'b0);
        tick();
        chk_out("slt_pos", 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 4'b1000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
        tick();
        chk_out("slt_min", 32'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'b0010, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0);
        tick();
        chk_out("and", 32'h00F0_1200, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'b0011, 32'hF000_0000, 32'h0000_000F, 1'b0);
        tick();
        chk_out("or", 32'hF000_000F, 1'b1, 1'b0, 1'b0, 1'b0);

        drive(1'b1, 4'b1111, 32'd3, 32'd4, 1'b0);
        tick();
        chk_out("illegal", 32'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);
        tick();
        chk_out("illegal_hold", 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);

        drive(1'b1, 4'b0000, 32'd2, 32'd3, 1'b0);
        tick();
        chk_out("add5", 32'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'b0000, 32'd10, 32'd10, 1'b1);
        tick();
        chk_out("flush_drop", 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef ALU_MUL_EN
        drive(1'b1, 4'b0110, 32'h0001_0003, 32'h0002_0005, 1'b0);
        tick();
        chk_out("mul_accept", 32'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 4'b0000, 32'd1, 32'd1, 1'b0);
        for (int i = 1; i < 32; i++) begin
            tick();
            chk("mul_busy", {31'd0, busy}, 32'd1);
            chk("mul_no_ov", {31'd0, out_valid}, 32'd0);
            chk("mul_result_held", result, 32'd5);
        end
        tick();
        chk_out("mul_done", 32'h000B_000F, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("add_after_mul", 32'd2, 1'b1, 1'b0, 1'b0, 1'b0);

        drive(1'b1, 4'b0110, 32'd7, 32'd9, 1'b0);
        tick();
        drive(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);
        repeat (9) tick();
        chk("pre_flush_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        tick();
        chk_out("mul_flush", 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        flush = 1'b0;
        begin
            int ov_seen;
            ov_seen = 0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (out_valid === 1'b1 || busy === 1'b1) ov_seen++;
            end
            chk("flush_no_ov", ov_seen, 32'd0);
        end
        drive(1'b1, 4'b0000, 32'd2, 32'd2, 1'b0);
        tick();
        chk_out("add4", 32'd4, 1'b1, 1'b0, 1'b0, 1'b0);

        drive(1'b1, 4'b0110, 32'd7, 32'd9, 1'b0);
        tick();
        drive(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk_out("mul_reset", 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b1, 4'b0110, 32'd3, 32'd4, 1'b0);
        tick();
        drive(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);
        repeat (32) tick();
        chk_out("mul_small", 32'd12, 1'b1, 1'b0, 1'b0, 1'b0);
`else
        drive(1'b1, 4'b0110, 32'd3, 32'd4, 1'b0);
        tick();
        chk_out("mul_illegal", 32'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);
        tick();
        chk_out("mul_illegal_idle", 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);

        drive(1'b1, 4'b0000, 32'h1234_0000, 32'h0000_5678, 1'b0);
        tick();
        chk_out("add_pre_rst", 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        chk_out("rst_mid", 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);
        tick();
        chk_out("rst_release", 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
